// File: rtl/spi2_mem_master_if.sv
// Host-side request/response bundle for spi2_mem_master.
// The master modport is the host issuing requests; the slave modport is the SPI engine.
interface spi2_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi2_mem_master.sv
// SPI word-oriented memory master: turns one host read/write request into a
// sequence of 16-bit SPI words (CS pulsed per word) and returns the read data.
// All pin outputs are registered from the state, so they lag the FSM by one clk.
module spi2_mem_master #(
    parameter int HALF_PERIOD = 2,
    parameter int CS_GAP      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi2_mem_master_if.slave       host,
    output logic                   spi_sck,
    output logic                   spi_cs,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BIT_LO = 3'd1,
        S_BIT_HI = 3'd2,
        S_TAIL   = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_timer;
    logic [3:0]  r_bit_cnt;
    logic [2:0]  r_word_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rx;
    logic        r_cs;
    logic        r_sck;
    logic        r_mosi;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;

    logic        w_accept;
    logic        w_tick;
    logic        w_last_bit;
    logic        w_last_word;
    logic [15:0] w_tx_word;
    logic        w_cs_next;
    logic        w_sck_next;
    logic        w_mosi_next;
    logic        w_rsp_valid_next;
    logic [15:0] w_rsp_rdata_next;

    assign w_accept    = host.req_valid && (r_state == S_IDLE);
    assign w_last_bit  = (r_bit_cnt == 4'd15);
    assign w_last_word = r_write ? (r_word_cnt == 3'd3) : (r_word_cnt == 3'd5);

    // End of the current timed phase: half-period for SCK phases/tail, CS_GAP for the gap.
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            S_BIT_LO, S_BIT_HI, S_TAIL: w_tick = (r_timer == HP_LAST);
            S_GAP:                      w_tick = (r_timer == GAP_LAST);
            default:                    w_tick = 1'b0;
        endcase
    end

    // Word currently being shifted out, selected by the word index and request type.
    always_comb begin
        w_tx_word = 16'h0000;
        case (r_word_cnt)
            3'd0:    w_tx_word = r_write ? 16'hC100 : 16'hC000;
            3'd1:    w_tx_word = r_addr[15:0];
            3'd2:    w_tx_word = r_addr[31:16];
            3'd3:    w_tx_word = r_write ? r_wdata : 16'h0000;
            3'd4:    w_tx_word = 16'h8004;
            default: w_tx_word = 16'h0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_BIT_LO;
            S_BIT_LO: if (w_tick)   w_state_next = S_BIT_HI;
            S_BIT_HI: if (w_tick)   w_state_next = w_last_bit ? S_TAIL : S_BIT_LO;
            S_TAIL:   if (w_tick)   w_state_next = S_GAP;
            S_GAP:    if (w_tick)   w_state_next = w_last_word ? S_DONE : S_BIT_LO;
            S_DONE:                 w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Next values of the registered pin and response outputs, decoded from the state.
    always_comb begin
        w_cs_next        = 1'b1;
        w_sck_next       = 1'b0;
        w_mosi_next      = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_rsp_rdata_next = r_rsp_rdata;
        case (r_state)
            S_BIT_LO: begin
                w_cs_next   = 1'b0;
                w_mosi_next = w_tx_word[4'd15 - r_bit_cnt];
            end
            S_BIT_HI: begin
                w_cs_next   = 1'b0;
                w_sck_next  = 1'b1;
                w_mosi_next = w_tx_word[4'd15 - r_bit_cnt];
            end
            S_TAIL: w_cs_next = 1'b0;
            S_DONE: begin
                w_rsp_valid_next = 1'b1;
                w_rsp_rdata_next = r_write ? 16'h0000 : r_rx;
            end
            default: ;
        endcase
    end

    // Phase timer: restarts at every phase boundary, idle outside timed states.
    always_ff @(posedge clk) begin
        if (rst)                                   r_timer <= 8'd0;
        else if (r_state == S_IDLE || r_state == S_DONE) r_timer <= 8'd0;
        else if (w_tick)                           r_timer <= 8'd0;
        else                                       r_timer <= r_timer + 8'd1;
    end

    // Bit counter advances at the end of each high phase and returns to 0 after bit 15.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE)              r_bit_cnt <= 4'd0;
        else if (r_state == S_BIT_HI && w_tick)    r_bit_cnt <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
    end

    // Word counter advances at the end of each inter-word gap, stopping at the last word.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE)              r_word_cnt <= 3'd0;
        else if (r_state == S_GAP && w_tick && !w_last_word) r_word_cnt <= r_word_cnt + 3'd1;
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 16'd0;
        end else if (w_accept) begin
            r_write <= host.req_write;
            r_addr  <= host.req_addr;
            r_wdata <= host.req_wdata;
        end
    end

    // MISO sampled on the last cycle of each high phase; first bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (rst)                                   r_rx <= 16'd0;
        else if (r_state == S_BIT_HI && w_tick)    r_rx <= {spi_miso, r_rx[15:1]};
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs        <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'h0000;
        end else begin
            r_cs        <= w_cs_next;
            r_sck       <= w_sck_next;
            r_mosi      <= w_mosi_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
        end
    end

    assign spi_cs         = r_cs;
    assign spi_sck        = r_sck;
    assign spi_mosi       = r_mosi;
    assign host.req_ready = (r_state == S_IDLE);
    assign host.busy      = (r_state != S_IDLE);
    assign host.rsp_valid = r_rsp_valid;
    assign host.rsp_rdata = r_rsp_rdata;

endmodule
